systolic_exec: RTL and testbench

Instruction executor for the 4x4 systolic array. It consumes the 5-bit `instruction` word presented by the instruction sequencer, decodes it, and drives the array's weight-load, activation-stream, accumulator-clear and result-drain strobes. It then returns a one-cycle `systolic_array_done` pulse so the sequencer advances to the next entry. It is the responder on the sequencer's instruction/done handshake.

---
 rtl/systolic_exec.sv | 124 ++++++++++++
 tb/tb_systolic_exec.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_exec.sv
// rtl/systolic_exec.sv - instruction executor driving the 4x4 systolic array strobes
// Decodes one sequencer instruction at a time and answers with a one-cycle done pulse.
module systolic_exec #(
    parameter int FLUSH_CYCLES = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] instruction,
    input  logic       array_ready,
    output logic       systolic_array_done,
    output logic       busy,
    output logic       w_load,
    output logic [1:0] w_row,
    output logic [2:0] w_bank,
    output logic       a_valid,
    output logic [2:0] a_idx,
    output logic       acc_clr,
    output logic       rd_en,
    output logic [1:0] rd_row
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOADW, S_STREAM, S_FLUSH, S_DRAIN, S_CLEAR, S_DONE
    } state_t;

    localparam bit         NO_FLUSH   = (FLUSH_CYCLES == 0);
    localparam logic [3:0] FLUSH_LAST = NO_FLUSH ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_next;
    logic [3:0] fcnt, fcnt_next;
    logic [1:0] op, op_next;
    logic [2:0] arg, arg_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
            fcnt  <= 4'd0;
            op    <= 2'd0;
            arg   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            fcnt  <= fcnt_next;
            op    <= op_next;
            arg   <= arg_next;
        end
    end

    // Strobes follow array_ready directly so a stalled cycle costs exactly one cycle.
    always_comb begin
        state_next          = state;
        cnt_next            = cnt;
        fcnt_next           = fcnt;
        op_next             = op;
        arg_next            = arg;
        systolic_array_done = 1'b0;
        busy                = (state != S_IDLE);
        w_load              = 1'b0;
        w_row               = 2'd0;
        w_bank              = 3'd0;
        a_valid             = 1'b0;
        a_idx               = 3'd0;
        acc_clr             = 1'b0;
        rd_en               = 1'b0;
        rd_row              = 2'd0;
        case (state)
            S_IDLE: begin
                if (instruction != 5'd0) begin
                    op_next   = instruction[4:3];
                    arg_next  = instruction[2:0];
                    cnt_next  = 3'd0;
                    fcnt_next = 4'd0;
                    case (instruction[4:3])
                        2'b00:   state_next = S_LOADW;
                        2'b01:   state_next = S_STREAM;
                        2'b10:   state_next = S_DRAIN;
                        default: state_next = S_CLEAR;
                    endcase
                end
            end
            S_LOADW: begin
                w_load = array_ready;
                w_row  = cnt[1:0];
                w_bank = arg;
                if (array_ready) begin
                    cnt_next = cnt + 3'd1;
                    if (cnt == 3'd3) state_next = S_DONE;
                end
            end
            S_STREAM: begin
                a_valid = array_ready;
                a_idx   = cnt;
                if (array_ready) begin
                    cnt_next = cnt + 3'd1;
                    if (cnt == arg) state_next = NO_FLUSH ? S_DONE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                fcnt_next = fcnt + 4'd1;
                if (fcnt == FLUSH_LAST) state_next = S_DONE;
            end
            S_DRAIN: begin
                rd_en  = array_ready;
                rd_row = cnt[1:0];
                if (array_ready) begin
                    cnt_next = cnt + 3'd1;
                    if (cnt == 3'd3) state_next = S_DONE;
                end
            end
            S_CLEAR: begin
                acc_clr = array_ready;
                if (array_ready) state_next = S_DONE;
            end
            S_DONE: begin
                systolic_array_done = 1'b1;
                state_next          = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_systolic_exec.sv
// tb/tb_systolic_exec.sv - directed self-checking bench for systolic_exec
// Cycle c is the interval after edge c; inputs are driven at its start and outputs read 1 ns later.
module tb_systolic_exec;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] instruction = 5'd0;
    logic       array_ready = 1'b1;

    logic       done, busy, w_load, a_valid, acc_clr, rd_en;
    logic [1:0] w_row, rd_row;
    logic [2:0] w_bank, a_idx;

    logic       done_z, busy_z, w_load_z, a_valid_z, acc_clr_z, rd_en_z;
    logic [1:0] w_row_z, rd_row_z;
    logic [2:0] w_bank_z, a_idx_z;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_exec #(.FLUSH_CYCLES(7)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .array_ready(array_ready),
        .systolic_array_done(done), .busy(busy), .w_load(w_load), .w_row(w_row),
        .w_bank(w_bank), .a_valid(a_valid), .a_idx(a_idx), .acc_clr(acc_clr),
        .rd_en(rd_en), .rd_row(rd_row)
    );

    systolic_exec #(.FLUSH_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .instruction(instruction), .array_ready(array_ready),
        .systolic_array_done(done_z), .busy(busy_z), .w_load(w_load_z), .w_row(w_row_z),
        .w_bank(w_bank_z), .a_valid(a_valid_z), .a_idx(a_idx_z), .acc_clr(acc_clr_z),
        .rd_en(rd_en_z), .rd_row(rd_row_z)
    );

    function automatic logic [16:0] outs();
        return {done, busy, w_load, w_row, w_bank, a_valid, a_idx, acc_clr, rd_en, rd_row};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        instruction = 5'b01011;
        array_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (outs() !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h want=0", outs());
        end
        instruction = 5'd0;
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL idle_halt c=%0d busy=%b done=%b want 0/0", c, busy, done);
            end
        end
    endtask

    task automatic test_loadw();
        int strobes = 0;
        for (int c = 0; c <= 7; c++) begin
            instruction = (c <= 5) ? 5'b00101 : 5'd0;
            array_ready = 1'b1;
            #1;
            n_cmp++;
            if (w_load !== (c >= 1 && c <= 4) || done !== (c == 5) || busy !== (c >= 1 && c <= 5)) begin
                n_err++;
                $display("FAIL loadw_ctl c=%0d w_load=%b done=%b busy=%b", c, w_load, done, busy);
            end
            if (w_load) begin
                strobes++;
                n_cmp++;
                if (w_row !== 2'(c - 1) || w_bank !== 3'd5) begin
                    n_err++;
                    $display("FAIL loadw_row c=%0d row=%0d bank=%0d want row=%0d bank=5", c, w_row, w_bank, c - 1);
                end
            end else begin
                n_cmp++;
                if (w_row !== 2'd0 || w_bank !== 3'd0) begin
                    n_err++;
                    $display("FAIL loadw_idle_idx c=%0d row=%0d bank=%0d want 0", c, w_row, w_bank);
                end
            end
            tick();
        end
        n_cmp++;
        if (strobes != 4) begin
            n_err++;
            $display("FAIL loadw_count got=%0d want=4", strobes);
        end
    endtask

    task automatic test_stream();
        for (int c = 0; c <= 13; c++) begin
            instruction = (c == 0) ? 5'b01011 : 5'd0;
            array_ready = 1'b1;
            #1;
            n_cmp++;
            if (a_valid !== (c >= 1 && c <= 4) || done !== (c == 12) || busy !== (c >= 1 && c <= 12)) begin
                n_err++;
                $display("FAIL stream_ctl c=%0d a_valid=%b done=%b busy=%b", c, a_valid, done, busy);
            end
            n_cmp++;
            if (a_idx !== ((c >= 1 && c <= 4) ? 3'(c - 1) : 3'd0)) begin
                n_err++;
                $display("FAIL stream_idx c=%0d got=%0d", c, a_idx);
            end
            n_cmp++;
            if (a_valid_z !== (c >= 1 && c <= 4) || done_z !== (c == 5)) begin
                n_err++;
                $display("FAIL stream_noflush c=%0d a_valid=%b done=%b want done at 5", c, a_valid_z, done_z);
            end
            tick();
        end
    endtask

    task automatic test_stall_drain();
        logic [1:0] exp_row [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        int k = 0;
        for (int c = 0; c <= 8; c++) begin
            instruction = (c == 0) ? 5'b10000 : 5'd0;
            array_ready = !(c == 2 || c == 3);
            #1;
            n_cmp++;
            if (rd_en !== (c == 1 || (c >= 4 && c <= 6)) || done !== (c == 7)) begin
                n_err++;
                $display("FAIL drain_ctl c=%0d rd_en=%b done=%b", c, rd_en, done);
            end
            if (rd_en && k < 4) begin
                n_cmp++;
                if (rd_row !== exp_row[k]) begin
                    n_err++;
                    $display("FAIL drain_row c=%0d got=%0d want=%0d", c, rd_row, exp_row[k]);
                end
                k++;
            end
            tick();
        end
        array_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [4:0] prog [4] = '{5'b11000, 5'b00001, 5'b01111, 5'b10000};
        int done_at [4] = '{2, 8, 25, 31};
        int pc = 0, nd = 0, nclr = 0, nw = 0, na = 0, nr = 0;
        for (int c = 0; c < 45; c++) begin
            instruction = (pc < 4) ? prog[pc] : 5'd0;
            array_ready = 1'b1;
            #1;
            if (acc_clr) nclr++;
            if (w_load) begin
                n_cmp++;
                if (w_bank !== 3'd1 || w_row !== 2'(nw)) begin
                    n_err++;
                    $display("FAIL seq_loadw c=%0d bank=%0d row=%0d want bank=1 row=%0d", c, w_bank, w_row, nw);
                end
                nw++;
            end
            if (a_valid) begin
                n_cmp++;
                if (a_idx !== 3'(na)) begin
                    n_err++;
                    $display("FAIL seq_stream c=%0d idx=%0d want=%0d", c, a_idx, na);
                end
                na++;
            end
            if (rd_en) nr++;
            if (done) begin
                n_cmp++;
                if (nd >= 4 || c != done_at[nd]) begin
                    n_err++;
                    $display("FAIL seq_done_time pulse=%0d at c=%0d", nd, c);
                end
                nd++;
                pc++;
            end
            tick();
        end
        n_cmp++;
        if (nd != 4 || nclr != 1 || nw != 4 || na != 8 || nr != 4 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL seq_totals done=%0d clr=%0d w=%0d a=%0d rd=%0d busy=%b want 4/1/4/8/4/0",
                     nd, nclr, nw, na, nr, busy);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic seen_done = 1'b0;
        instruction = 5'b01011;
        array_ready = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++;
        if (a_idx !== 3'd2 || a_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre idx=%0d valid=%b want 2/1", a_idx, a_valid);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 17'd0) begin
            n_err++;
            $display("FAIL rst_mid_async got=%h want=0", outs());
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (seen_done !== 1'b0 || a_valid !== 1'b1 || a_idx !== 3'd0) begin
            n_err++;
            $display("FAIL rst_mid_restart done_seen=%b valid=%b idx=%0d want 0/1/0", seen_done, a_valid, a_idx);
        end
        instruction = 5'd0;
        tick();
        n_cmp++;
        if (a_idx !== 3'd1) begin
            n_err++;
            $display("FAIL rst_mid_next idx=%0d want=1", a_idx);
        end
    endtask

    initial begin
        test_reset();
        test_loadw();
        test_stream();
        test_stall_drain();
        test_back_to_back();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
